// File: rtl/gate_resp_checker.sv
// Response checker for a 3-input gate: scores {a,b,c,y} samples against a truth
// table over a run of N_VEC accepted samples and captures the first mismatch.
module gate_resp_checker #(
  parameter int              N_VEC  = 8,
  parameter int              CNT_W  = 8,
  parameter logic [7:0]      EXP_TT = 8'b1000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             smp_valid,
  output logic             smp_ready,
  input  logic             smp_a,
  input  logic             smp_b,
  input  logic             smp_c,
  input  logic             smp_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [2:0]       first_fail_vec,
  output logic             first_fail_y
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VEC - 1);

  state_t           state_q;
  logic [CNT_W-1:0] pass_cnt_q;
  logic [CNT_W-1:0] fail_cnt_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] ff_idx_q;
  logic [2:0]       ff_vec_q;
  logic             ff_y_q;

  logic [2:0]       vec;
  logic             exp_y;
  logic             match;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign vec   = {smp_a, smp_b, smp_c};
  assign exp_y = EXP_TT[vec];
  assign match = (smp_y == exp_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      idx_q      <= '0;
      ff_idx_q   <= '0;
      ff_vec_q   <= '0;
      ff_y_q     <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          // smp_ready is high throughout RUN, so valid alone marks an accept
          if (smp_valid) begin
            if (match) begin
              pass_cnt_q <= sat_inc(pass_cnt_q);
            end else begin
              fail_cnt_q <= sat_inc(fail_cnt_q);
              if (fail_cnt_q == '0) begin
                ff_idx_q <= idx_q;
                ff_vec_q <= vec;
                ff_y_q   <= smp_y;
              end
            end
            idx_q <= sat_inc(idx_q);
            if (idx_q == LAST_IDX) state_q <= S_DONE;
          end
        end
        default: begin
          if (start) begin
            state_q    <= S_RUN;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            idx_q      <= '0;
            ff_idx_q   <= '0;
            ff_vec_q   <= '0;
            ff_y_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy           = (state_q == S_RUN);
  assign smp_ready      = busy;
  assign done           = (state_q == S_DONE);
  assign pass           = done && (fail_cnt_q == '0);
  assign pass_cnt       = pass_cnt_q;
  assign fail_cnt       = fail_cnt_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_vec = ff_vec_q;
  assign first_fail_y   = ff_y_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Scoreboard bench for gate_resp_checker: AND3/N_VEC=8 instance with a run-level
// reference model, plus a NAND3/N_VEC=3 instance exercised with directed runs.
module tb_gate_resp_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, smp_valid, smp_a, smp_b, smp_c, smp_y;
  logic       smp_ready, busy, done, pass;
  logic [7:0] pass_cnt, fail_cnt, first_fail_idx;
  logic [2:0] first_fail_vec;
  logic       first_fail_y;

  logic       t_start, t_valid, t_a, t_b, t_c, t_y;
  logic       t_ready, t_busy, t_done, t_pass;
  logic [7:0] t_pass_cnt, t_fail_cnt, t_ff_idx;
  logic [2:0] t_ff_vec;
  logic       t_ff_y;

  gate_resp_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .smp_a(smp_a), .smp_b(smp_b), .smp_c(smp_c), .smp_y(smp_y), .busy(busy), .done(done),
    .pass(pass), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx),
    .first_fail_vec(first_fail_vec), .first_fail_y(first_fail_y)
  );

  gate_resp_checker #(.N_VEC(3), .CNT_W(8), .EXP_TT(8'b0111_1111)) u_nand (
    .clk(clk), .rst_n(rst_n), .start(t_start), .smp_valid(t_valid), .smp_ready(t_ready),
    .smp_a(t_a), .smp_b(t_b), .smp_c(t_c), .smp_y(t_y), .busy(t_busy), .done(t_done),
    .pass(t_pass), .pass_cnt(t_pass_cnt), .fail_cnt(t_fail_cnt), .first_fail_idx(t_ff_idx),
    .first_fail_vec(t_ff_vec), .first_fail_y(t_ff_y)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         pc;
    int         fc;
    int         fidx;
    logic [2:0] fvec;
    logic       fy;
    logic       pass;
  } res_t;

  res_t       exp_q[$];
  logic [3:0] acc_q[$];
  bit         m_run  = 0;
  bit         m_done = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit and3(input logic [2:0] v);
    return v[2] & v[1] & v[0];
  endfunction

  // Reference: score a completed run from the list of accepted samples.
  function automatic res_t eval_run();
    res_t r;
    r = '{pc: 0, fc: 0, fidx: 0, fvec: 3'b000, fy: 1'b0, pass: 1'b0};
    foreach (acc_q[i]) begin
      if (acc_q[i][0] == and3(acc_q[i][3:1])) r.pc++;
      else begin
        if (r.fc == 0) begin
          r.fidx = i;
          r.fvec = acc_q[i][3:1];
          r.fy   = acc_q[i][0];
        end
        r.fc++;
      end
    end
    r.pass = (r.fc == 0);
    return r;
  endfunction

  task automatic cycle(input bit st, input bit v, input logic [2:0] vec, input bit y);
    @(negedge clk);
    start = st; smp_valid = v; {smp_a, smp_b, smp_c} = vec; smp_y = y;
    if (st && !m_run) begin
      m_run = 1; m_done = 0; acc_q.delete();
    end else if (m_run && v) begin
      acc_q.push_back({vec, y});
      if (acc_q.size() == 8) begin
        exp_q.push_back(eval_run());
        m_run = 0; m_done = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
  endtask

  // Monitor: compares handshake/state every cycle and scores each completed run.
  bit done_prev = 0;
  bit busy_prev = 0;
  initial begin
    res_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("busy", busy, m_run);
      chk("smp_ready", smp_ready, m_run);
      chk("done", done, m_done);
      if (busy && !busy_prev) begin
        chk("clr_pass_cnt", pass_cnt, 0);
        chk("clr_fail_cnt", fail_cnt, 0);
        chk("clr_ff_idx", first_fail_idx, 0);
        chk("clr_ff_vec", first_fail_vec, 0);
        chk("clr_pass", pass, 0);
      end
      if (done && !done_prev) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("pass_cnt", pass_cnt, e.pc);
          chk("fail_cnt", fail_cnt, e.fc);
          chk("pass", pass, e.pass);
          chk("first_fail_idx", first_fail_idx, e.fidx);
          chk("first_fail_vec", first_fail_vec, e.fvec);
          chk("first_fail_y", first_fail_y, e.fy);
        end
      end
      done_prev = done;
      busy_prev = busy;
    end
  end

  initial begin
    int guard;
    logic [2:0] v;
    rst_n = 0; start = 0; smp_valid = 0; smp_a = 0; smp_b = 0; smp_c = 0; smp_y = 0;
    t_start = 0; t_valid = 0; t_a = 0; t_b = 0; t_c = 0; t_y = 0;
    #1;
    chk("rst_ready", smp_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    // samples offered in IDLE are dropped
    for (int i = 0; i < 4; i++) cycle(0, 1, 3'(i), 1'b1);

    // all-pass run
    cycle(1, 0, 3'b000, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 3'(i), and3(3'(i)));
    idle(2);

    // failures at indices 2 and 5
    cycle(1, 0, 3'b000, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 3'(i), and3(3'(i)) ^ (i == 2 || i == 5));
    idle(2);

    // gaps every other cycle, valid held after done
    cycle(1, 0, 3'b000, 0);
    guard = 0;
    while (m_run && guard < 40) begin
      v = 3'($urandom_range(0, 7));
      cycle(0, guard % 2 == 0, v, and3(v) ^ ($urandom_range(0, 3) == 0));
      guard++;
    end
    for (int i = 0; i < 4; i++) cycle(0, 1, 3'b111, 1'b0);

    // start in RUN ignored (sample still accepted), then restart from DONE
    cycle(1, 0, 3'b000, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 3'b111, 1'b0);
    cycle(1, 1, 3'b011, 1'b1);
    for (int i = 0; i < 4; i++) cycle(0, 1, 3'(i), and3(3'(i)));
    idle(2);
    cycle(1, 0, 3'b000, 0);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      guard = 0;
      while (m_run && guard < 60) begin
        v = 3'($urandom_range(0, 7));
        cycle($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, v,
              and3(v) ^ ($urandom_range(0, 4) == 0));
        guard++;
      end
      idle($urandom_range(0, 3));
      cycle(1, 0, 3'b000, 0);
    end

    // async reset mid-run with 3 accepted
    for (int i = 0; i < 3; i++) cycle(0, 1, 3'b101, 1'b1);
    @(negedge clk);
    smp_valid = 0;
    #2 rst_n = 0;
    m_run = 0; m_done = 0; acc_q.delete();
    #1;
    chk("arst_ready", smp_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_fail_cnt", fail_cnt, 0);
    chk("arst_ff_idx", first_fail_idx, 0);
    chk("arst_ff_vec", first_fail_vec, 0);
    chk("arst_ff_y", first_fail_y, 0);
    @(negedge clk);
    rst_n = 1;
    idle(2);

    // NAND3, N_VEC=3: all pass including {1,1,1} y=0
    @(negedge clk); t_start = 1;
    @(negedge clk); t_start = 0; t_valid = 1; {t_a, t_b, t_c} = 3'b111; t_y = 0;
    @(negedge clk); {t_a, t_b, t_c} = 3'b010; t_y = 1;
    @(negedge clk); {t_a, t_b, t_c} = 3'b000; t_y = 1;
    chk("nand_done_early", t_done, 0);
    @(negedge clk);
    chk("nand_done", t_done, 1);
    chk("nand_pass", t_pass, 1);
    chk("nand_pass_cnt", t_pass_cnt, 3);
    chk("nand_ready_done", t_ready, 0);
    @(negedge clk);
    chk("nand_hold_cnt", t_pass_cnt, 3);
    t_valid = 0;
    // NAND3 run with mismatches at index 0 and 2
    @(negedge clk); t_start = 1;
    @(negedge clk); t_start = 0; t_valid = 1; {t_a, t_b, t_c} = 3'b111; t_y = 1;
    @(negedge clk); {t_a, t_b, t_c} = 3'b001; t_y = 1;
    @(negedge clk); {t_a, t_b, t_c} = 3'b100; t_y = 0;
    @(negedge clk); t_valid = 0;
    chk("nand2_done", t_done, 1);
    chk("nand2_pass", t_pass, 0);
    chk("nand2_fail_cnt", t_fail_cnt, 2);
    chk("nand2_pass_cnt", t_pass_cnt, 1);
    chk("nand2_ff_idx", t_ff_idx, 0);
    chk("nand2_ff_vec", t_ff_vec, 7);
    chk("nand2_ff_y", t_ff_y, 1);

    idle(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
